wb_reg_master: RTL

Wishbone classic single-access initiator that drives the MAC register slave port (adr[11:2], 32-bit data, byte selects, ack/err). It accepts one register command at a time over a valid/ready request channel and runs one Wishbone cycle per command. It returns read data and status (ok/err/timeout) over a valid/ready response channel. It sits between the host/config sequencer and the MAC register block.

---
 rtl/wb_reg_master.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wb_reg_master.sv
// ============================================================================
// Module      : wb_reg_master
// Description : Wishbone classic single-access initiator for the MAC register
//               port; one bus cycle per request, result returned as response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_reg_master #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // Request channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [9:0]  cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_wdata,
    // Response channel
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    // Wishbone initiator
    output logic [9:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam bit          C_TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] C_TO_LAST = C_TO_EN ? 16'(TIMEOUT_CYCLES - 1) : 16'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic        cmd_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        rsp_timeout_q;
    logic [9:0]  wb_adr_q;
    logic [31:0] wb_dat_q;
    logic [3:0]  wb_sel_q;
    logic        wb_we_q;
    logic        wb_cyc_q;
    logic        wb_stb_q;

    logic        w_to_hit;
    assign w_to_hit = C_TO_EN && (cnt_q == C_TO_LAST);

    // Asynchronous reset drops cyc/stb immediately and discards any pending response.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wb_adr_q      <= 10'd0;
            wb_dat_q      <= 32'd0;
            wb_sel_q      <= 4'd0;
            wb_we_q       <= 1'b0;
            wb_cyc_q      <= 1'b0;
            wb_stb_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wb_we_q     <= cmd_we;
                        wb_adr_q    <= cmd_adr;
                        wb_sel_q    <= cmd_sel;
                        wb_dat_q    <= cmd_wdata;
                        wb_cyc_q    <= 1'b1;
                        wb_stb_q    <= 1'b1;
                        cnt_q       <= 16'd0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_BUS;
                    end
                end

                ST_BUS: begin
                    if (wb_err_i || wb_ack_i || w_to_hit) begin
                        // Error has priority over ack; timeout only when neither arrived.
                        rsp_err_q     <= wb_err_i;
                        rsp_timeout_q <= !wb_err_i && !wb_ack_i;
                        rsp_rdata_q   <= (!wb_err_i && wb_ack_i && !wb_we_q) ? wb_dat_i : 32'd0;
                        rsp_valid_q   <= 1'b1;
                        wb_cyc_q      <= 1'b0;
                        wb_stb_q      <= 1'b0;
                        wb_we_q       <= 1'b0;
                        wb_sel_q      <= 4'd0;
                        wb_adr_q      <= 10'd0;
                        wb_dat_q      <= 32'd0;
                        state_q       <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q   <= 1'b0;
                        rsp_err_q     <= 1'b0;
                        rsp_timeout_q <= 1'b0;
                        cmd_ready_q   <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    wb_cyc_q    <= 1'b0;
                    wb_stb_q    <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;
    assign wb_adr_o    = wb_adr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_sel_o    = wb_sel_q;
    assign wb_we_o     = wb_we_q;
    assign wb_cyc_o    = wb_cyc_q;
    assign wb_stb_o    = wb_stb_q;

endmodule

`default_nettype wire
